// File: rtl/tsmm_pkg.sv
// tsmm_pkg: definitions shared across the tall-skinny matrix-multiply blocks.
//   - Default datapath widths and frame geometry.
//   - idx_w(n): index width for a counter that spans 0..n-1. It is never
//     smaller than 1 bit.
//   - tsmm_cidx_t: the C-element index tag. The upstream operand sequencer
//     uses the same tag.
package tsmm_pkg;

    localparam int TSMM_DATA_W = 32;
    localparam int TSMM_ACC_W  = 40;
    localparam int TSMM_K_DIM  = 16;
    localparam int TSMM_M_ROWS = 1024;
    localparam int TSMM_N_COLS = 16;

    // Index width for a counter over 0..n-1. It is at least 1 bit, so that a
    // degenerate dimension still has a real port.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int TSMM_ROW_W = idx_w(TSMM_M_ROWS);
    localparam int TSMM_COL_W = idx_w(TSMM_N_COLS);

    typedef struct packed {
        logic [TSMM_ROW_W-1:0] row;
        logic [TSMM_COL_W-1:0] col;
        logic                  last;
    } tsmm_cidx_t;

endpackage : tsmm_pkg

// File: rtl/tsmm_idx_counter.sv
// tsmm_idx_counter: cascaded wrap counters k -> col -> row. They walk the C
// matrix in row-major order, and each C element takes K_DIM beats.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous return of all counters to zero (has priority)
//   advance      one beat consumed this cycle
//   k_first      k == 0. The beat at the head of an element starts a fresh sum.
//   k_last       k == K_DIM-1. The current beat completes an element.
//   row, col     index of the C element currently being accumulated
//   frame_last   current element is C[M_ROWS-1][N_COLS-1]
module tsmm_idx_counter
    import tsmm_pkg::*;
#(
    parameter int K_DIM  = TSMM_K_DIM,
    parameter int M_ROWS = TSMM_M_ROWS,
    parameter int N_COLS = TSMM_N_COLS,
    parameter int K_W    = idx_w(K_DIM),
    parameter int ROW_W  = idx_w(M_ROWS),
    parameter int COL_W  = idx_w(N_COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic             k_first,
    output logic             k_last,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             frame_last
);

    localparam logic [K_W-1:0]   K_MAX   = K_W'(K_DIM - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(M_ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(N_COLS - 1);

    logic [K_W-1:0] k;
    logic           row_last;
    logic           col_last;

    assign k_first    = (k == '0);
    assign k_last     = (k == K_MAX);
    assign row_last   = (row == ROW_MAX);
    assign col_last   = (col == COL_MAX);
    assign frame_last = row_last && col_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k   <= '0;
            row <= '0;
            col <= '0;
        end else if (clear) begin
            k   <= '0;
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (k_last) begin
                k <= '0;
                if (col_last) begin
                    col <= '0;
                    // At the end of a frame the row wraps back to 0 for the next frame.
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule : tsmm_idx_counter

// File: rtl/tsmm_dot_accumulator.sv
// tsmm_dot_accumulator: sums each run of K_DIM consecutive signed products
// into one C element. The element is emitted with its (row, col) index
// through a single output holding register.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// valid must not depend on ready. While valid is high and ready is low, the
// producer holds its payload stable.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous frame abort. It drops the partial sum,
//                         the indices and any held output, and it discards a
//                         beat offered in the same cycle.
//   in_valid/in_ready     product beat handshake. in_ready = !out_valid || out_ready.
//   in_data               signed product (DATA_W)
//   out_valid/out_ready   C element handshake
//   out_data              signed sum (ACC_W, wraps modulo 2^ACC_W)
//   out_row, out_col      index of out_data
//   out_last              out_data is the final element of the frame
//   busy                  a partial sum or a held output exists
module tsmm_dot_accumulator
    import tsmm_pkg::*;
#(
    parameter int DATA_W = TSMM_DATA_W,
    parameter int ACC_W  = TSMM_ACC_W,
    parameter int K_DIM  = TSMM_K_DIM,
    parameter int M_ROWS = TSMM_M_ROWS,
    parameter int N_COLS = TSMM_N_COLS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_data,
    output logic [idx_w(M_ROWS)-1:0]   out_row,
    output logic [idx_w(N_COLS)-1:0]   out_col,
    output logic                       out_last,
    output logic                       busy
);

    localparam int ROW_W = idx_w(M_ROWS);
    localparam int COL_W = idx_w(N_COLS);

    logic             accept;
    logic             k_first;
    logic             k_last;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             frame_last;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] acc_sum;

    // The only backpressure is a held output that the consumer is not taking
    // this cycle. When the output drains and a new element completes in the
    // same cycle, the stream runs without bubbles.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !clear;

    assign in_ext  = ACC_W'($signed(in_data));
    // The first beat of an element replaces the stale sum, so acc never
    // needs its own reset between elements. With K_DIM == 1 every beat is a
    // first beat, and the sum is just the extended input.
    assign acc_sum = (k_first ? '0 : acc) + in_ext;

    assign busy = out_valid || !k_first;

    tsmm_idx_counter #(
        .K_DIM  (K_DIM),
        .M_ROWS (M_ROWS),
        .N_COLS (N_COLS)
    ) u_idx (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .advance    (accept),
        .k_first    (k_first),
        .k_last     (k_last),
        .row        (cur_row),
        .col        (cur_col),
        .frame_last (frame_last)
    );

    // Partial-sum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (accept && !k_last) begin
            acc <= acc_sum;
        end
    end

    // Output holding register. A completing beat has priority over draining,
    // so a drain and a reload in the same cycle keep out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (accept && k_last) begin
            out_valid <= 1'b1;
            out_data  <= acc_sum;
            out_row   <= cur_row;
            out_col   <= cur_col;
            out_last  <= frame_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : tsmm_dot_accumulator

// File: tb/tb_tsmm_dot_accumulator.sv
module tb_tsmm_dot_accumulator;

    localparam int DW = 32;
    localparam int AW = 40;
    localparam int KD = 4;
    localparam int MR = 2;
    localparam int NC = 3;
    localparam int RW = 1;
    localparam int CW = 2;
    localparam int EW = AW + RW + CW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (K_DIM=4) ----------------
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_data;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_last;
    logic          busy;

    tsmm_dot_accumulator #(
        .DATA_W(DW), .ACC_W(AW), .K_DIM(KD), .M_ROWS(MR), .N_COLS(NC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy)
    );

    // ---------------- DUT (K_DIM=1) ----------------
    logic          k1_clear = 1'b0;
    logic          k1_in_valid = 1'b0;
    logic          k1_in_ready;
    logic [DW-1:0] k1_in_data = '0;
    logic          k1_out_valid;
    logic          k1_out_ready = 1'b1;
    logic [AW-1:0] k1_out_data;
    logic [RW-1:0] k1_out_row;
    logic [CW-1:0] k1_out_col;
    logic          k1_out_last;
    logic          k1_busy;

    tsmm_dot_accumulator #(
        .DATA_W(DW), .ACC_W(AW), .K_DIM(1), .M_ROWS(MR), .N_COLS(NC)
    ) dut_k1 (
        .clk(clk), .rst_n(rst_n), .clear(k1_clear),
        .in_valid(k1_in_valid), .in_ready(k1_in_ready), .in_data(k1_in_data),
        .out_valid(k1_out_valid), .out_ready(k1_out_ready), .out_data(k1_out_data),
        .out_row(k1_out_row), .out_col(k1_out_col), .out_last(k1_out_last), .busy(k1_busy)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp1_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] d, input int r, input int c, input logic l);
        exp_q.push_back({d, RW'(r), CW'(c), l});
    endtask

    task automatic push_exp1(input logic [AW-1:0] d, input int r, input int c, input logic l);
        exp1_q.push_back({d, RW'(r), CW'(c), l});
    endtask

    // Monitors: pop and compare on every output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("k4_unexpected_output", {20'd0, out_data, out_row, out_col, out_last}, 64'd0);
            end else begin
                check("k4_output", {20'd0, out_data, out_row, out_col, out_last},
                      {20'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && k1_out_valid && k1_out_ready) begin
            if (exp1_q.size() == 0) begin
                check("k1_unexpected_output", {20'd0, k1_out_data, k1_out_row, k1_out_col, k1_out_last}, 64'd0);
            end else begin
                check("k1_output", {20'd0, k1_out_data, k1_out_row, k1_out_col, k1_out_last},
                      {20'd0, exp1_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic send(input logic [DW-1:0] d);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        if (!got) check("k4_send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send1(input logic [DW-1:0] d);
        bit got = 1'b0;
        k1_in_valid = 1'b1;
        k1_in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            if (k1_in_ready) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        k1_in_valid = 1'b0;
        if (!got) check("k1_send_timeout", 64'd0, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] k1_vec [7];
    logic [AW-1:0] k1_exp [7];
    int c0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_idx",   64'({out_row, out_col, out_last}), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        sync();

        // Streaming 1..24, no stalls
        push_exp(40'd10, 0, 0, 1'b0);
        push_exp(40'd26, 0, 1, 1'b0);
        push_exp(40'd42, 0, 2, 1'b0);
        push_exp(40'd58, 1, 0, 1'b0);
        push_exp(40'd74, 1, 1, 1'b0);
        push_exp(40'd90, 1, 2, 1'b1);
        c0 = cyc;
        for (int i = 1; i <= 24; i++) send(DW'(i));
        check("stream_cycles", 64'(cyc - c0), 64'd24);
        sync();

        // Negative and large positive sums, frame wrapped to (0,0)
        push_exp(40'hFE00000000, 0, 0, 1'b0);
        push_exp(40'h01FFFFFFFC, 0, 1, 1'b0);
        for (int i = 0; i < 4; i++) send(32'h80000000);
        for (int i = 0; i < 4; i++) send(32'h7FFFFFFF);
        sync();
        sync();

        // Backpressure: output held, input stalls, nothing lost
        push_exp(40'd10, 0, 2, 1'b0);
        push_exp(40'd26, 1, 0, 1'b0);
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(DW'(i));
        check("bp_in_ready_drop", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data",  64'(out_data),  64'd10);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        sync();
        out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) send(DW'(i));
        sync();
        sync();

        // clear mid-element at (1,1)
        send(32'd1);
        send(32'd2);
        check("clr_busy_before", 64'(busy), 64'd1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd99;
        sync();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_busy_after", 64'(busy), 64'd0);
        check("clr_out_valid",  64'(out_valid), 64'd0);
        push_exp(40'd20, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) send(32'd5);
        sync();
        sync();

        // Reset while an output is held at (0,1)
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'd3);
        check("rst2_valid_before", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_out_data",  64'(out_data),  64'd0);
        check("rst2_out_idx",   64'({out_row, out_col, out_last}), 64'd0);
        check("rst2_busy",      64'(busy),      64'd0);
        check("rst2_in_ready",  64'(in_ready),  64'd1);
        sync();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sync();
        push_exp(40'd16, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) send(32'd4);
        sync();
        sync();

        // K_DIM=1: output reloaded every cycle, indices wrap after 6
        k1_vec[0] = 32'd5;        k1_exp[0] = 40'd5;
        k1_vec[1] = 32'hFFFFFFFF; k1_exp[1] = 40'hFFFFFFFFFF;
        k1_vec[2] = 32'd7;        k1_exp[2] = 40'd7;
        k1_vec[3] = 32'd0;        k1_exp[3] = 40'd0;
        k1_vec[4] = 32'h80000000; k1_exp[4] = 40'hFF80000000;
        k1_vec[5] = 32'd123;      k1_exp[5] = 40'd123;
        k1_vec[6] = 32'd9;        k1_exp[6] = 40'd9;
        for (int i = 0; i < 7; i++) push_exp1(k1_exp[i], (i % 6) / 3, i % 3, i == 5);
        for (int i = 0; i < 7; i++) begin
            send1(k1_vec[i]);
            k1_in_valid = 1'b1;
            check("k1_valid_steady", 64'(k1_out_valid), 64'd1);
        end
        k1_in_valid = 1'b0;
        sync();
        sync();

        // Drain scoreboards (bounded)
        for (int t = 0; t < 20 && (exp_q.size() != 0 || exp1_q.size() != 0); t++) sync();
        check("k4_queue_empty", 64'(exp_q.size()), 64'd0);
        check("k1_queue_empty", 64'(exp1_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_tsmm_dot_accumulator
